prog_mem_responder: RTL and testbench
=====================================

Name: prog_mem_responder

Overview:
- Memory-side responder for the simple processor's instruction fetch and data RAM interfaces.
- Holds a 256x16 instruction memory, which it serves on pc/rom_en/ir, and a 256x8 data RAM, which it serves on cs_ram/wr_ram/addr_ram.
- A byte-stream program loader fills the instruction memory.
- Once loading completes, the block releases the CPU from hold and pulses start.

Parameters:
- IAW, 8, instruction address width (depth 2^IAW)
- IW, 16, instruction word width (two load bytes per word)
- DAW, 8, data RAM address width
- DW, 8, data RAM word width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  loader byte valid
- load_data  in  8  loader byte; high byte of each word first
- load_last  in  1  marks the final byte of the program
- load_ready  out  1  loader may accept a byte this cycle
- reload  in  1  one-cycle request to re-enter loading
- pc  in  IAW  fetch address from CPU
- rom_en  in  1  fetch enable
- ir  out  IW  fetched instruction
- cs_ram  in  1  data RAM chip select
- wr_ram  in  1  1 = write, 0 = read (qualified by cs_ram)
- addr_ram  in  DAW  data RAM address
- ram_wdata  in  DW  write data (CPU alu_out)
- ram_rdata  out  DW  read data
- start  out  1  one-cycle pulse when the program is ready
- cpu_hold  out  1  high whenever state is not RUN; drives the CPU reset
- prog_len  out  IAW+1  number of words loaded
- overflow  out  1  sticky; set when the memory fills before load_last

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE, byte phase = HI, word pointer = 0.
  - ir = 0, ram_rdata = 0, start = 0, cpu_hold = 1, prog_len = 0, overflow = 0.
  - load_ready = 0 in the reset cycle.
  - Memory arrays are not cleared.
- IDLE: load_ready = 1. Go to LOAD on the first accepted byte, which is treated as a HI byte.
- Byte accept: a byte is accepted when load_valid and load_ready are both high at the rising edge.
- LOAD, HI phase: latch the byte into the upper half of the word. If load_last is also high, write {byte, 8'h00} at the pointer in the same edge and finish.
- LOAD, LO phase: write {hi, byte} at the pointer on the accepting edge, then increment the pointer. If load_last is high, finish.
- Finish:
  - prog_len = pointer + 1.
  - Next state DONE, with load_ready = 0.
  - Returning to IDLE from DONE or RUN resets the pointer to 0.
- Full memory: when the word at address 2^IAW-1 is written without load_last:
  - overflow is set and prog_len = 2^IAW.
  - The block finishes as if load_last had been seen.
  - The pointer does not wrap.
- DONE: lasts exactly one cycle. start = 1, cpu_hold = 1. Next state RUN.
  - Timing: last byte accepted at edge N gives start high for cycle N+1 and cpu_hold low from cycle N+2.
- RUN: start = 0, cpu_hold = 0, load_ready = 0.
- Fetch (any state):
  - rom_en high at edge N gives ir = imem[pc] after edge N.
  - rom_en low holds ir.
  - In IDLE and LOAD, ir is forced to 0.
  - Read-during-load returns 0, never partial data.
- Data RAM:
  - cs_ram & wr_ram at an edge: dmem[addr_ram] <= ram_wdata.
  - cs_ram & !wr_ram: ram_rdata = dmem[addr_ram] after the edge (one-cycle latency).
  - cs_ram low: ram_rdata holds.
  - A read and a write cannot coincide (single port).
- reload:
  - In RUN or DONE: next state IDLE, cpu_hold = 1 from the next cycle, prog_len kept, overflow cleared.
  - In IDLE or LOAD: ignored.
  - reload together with rom_en in the same cycle: reload wins for state; the fetch still completes, then ir is forced to 0 in IDLE.
- Reset mid-load: returns to IDLE. Words already written stay in memory, but prog_len = 0.
- Data RAM is accessible in all states (the CPU is held in reset outside RUN anyway).

Decomposition:
- Package prog_mem_pkg holds:
  - state enum {IDLE, LOAD, DONE, RUN};
  - byte-phase enum {HI, LO};
  - width constants IAW, IW, DAW, DW.
- One sub-module, sync_spram:
  - parameterised address and data width, synchronous write and registered read, with a read enable;
  - instantiated twice: instruction memory, with the loader driving the write port, and the data RAM.
- The loader FSM and the fetch mux stay in the top module.

Test Plan:
- Load bytes 12 34 56 78 with last on 78: expect imem[0]=1234, imem[1]=5678, prog_len=2, start high exactly one cycle, then cpu_hold=0; then pc=1, rom_en=1 gives ir=5678 the next cycle.
- Odd-length load 9A BC DE, last on DE: expect imem[1]=DE00, prog_len=2, overflow=0.
- Stream 512 bytes with no last: expect overflow=1, prog_len=256, imem[255] = last pair, load_ready=0 afterwards.
- In RUN: write 0x5A to addr 0x10 via cs_ram=1, wr_ram=1; then read addr 0x10 gives ram_rdata=5A one cycle later; with cs_ram=0, ram_rdata holds 5A.
- rst asserted after 3 bytes: expect state IDLE, prog_len=0, cpu_hold=1; a fresh 2-byte load gives prog_len=1.
- reload pulse in RUN with rom_en=1: expect cpu_hold=1 next cycle, ir=0 thereafter, load_ready=1, new load overwrites word 0.

Source files
------------

// File: rtl/prog_mem_pkg.sv
// Shared types and widths for the program memory responder.
package prog_mem_pkg;

   localparam int unsigned IAW = 8;
   localparam int unsigned IW  = 16;
   localparam int unsigned DAW = 8;
   localparam int unsigned DW  = 8;

   typedef enum logic [1:0] {IDLE, LOAD, DONE, RUN} state_e;
   typedef enum logic {HI, LO} phase_e;

endpackage

// File: rtl/prog_mem_responder_sync_spram.sv
// Single-port RAM: synchronous write, registered read with read enable.
module sync_spram #(
   parameter int unsigned AddrWidth = 8,
   parameter int unsigned DataWidth = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 we_i,
   input  logic                 re_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [DataWidth-1:0] wdata_i,
   output logic [DataWidth-1:0] rdata_o
);

   logic [DataWidth-1:0] mem_q [2**AddrWidth];
   logic [DataWidth-1:0] rdata_q;

   // Array contents survive reset; only the read register is cleared.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_responder.sv
// Instruction/data memory responder with a byte-stream program loader that
// releases the CPU from hold once a program is in place.
module prog_mem_responder
   import prog_mem_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           load_valid,
   input  logic [7:0]     load_data,
   input  logic           load_last,
   output logic           load_ready,
   input  logic           reload,
   input  logic [IAW-1:0] pc,
   input  logic           rom_en,
   output logic [IW-1:0]  ir,
   input  logic           cs_ram,
   input  logic           wr_ram,
   input  logic [DAW-1:0] addr_ram,
   input  logic [DW-1:0]  ram_wdata,
   output logic [DW-1:0]  ram_rdata,
   output logic           start,
   output logic           cpu_hold,
   output logic [IAW:0]   prog_len,
   output logic           overflow
);

   localparam logic [IAW-1:0] PtrMax = '1;
   localparam logic [IAW-1:0] PtrOne = IAW'(1);
   localparam logic [IAW:0]   LenOne = (IAW + 1)'(1);

   state_e            state_q, state_d;
   phase_e            phase_q, phase_d;
   logic [IAW-1:0]    ptr_q, ptr_d;
   logic [IW/2-1:0]   hi_q, hi_d;
   logic [IAW:0]      prog_len_q, prog_len_d;
   logic              overflow_q, overflow_d;

   logic              loading;
   logic              accept;
   logic              finish;
   logic              imem_we;
   logic              imem_re;
   logic [IAW-1:0]    imem_addr;
   logic [IW-1:0]     imem_wdata;
   logic [IW-1:0]     imem_rdata;

   assign loading    = (state_q == IDLE) || (state_q == LOAD);
   assign load_ready = loading && !rst;
   assign accept     = load_valid && load_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         phase_q    <= HI;
         ptr_q      <= '0;
         hi_q       <= '0;
         prog_len_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         ptr_q      <= ptr_d;
         hi_q       <= hi_d;
         prog_len_q <= prog_len_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      ptr_d      = ptr_q;
      hi_d       = hi_q;
      prog_len_d = prog_len_q;
      overflow_d = overflow_q;
      imem_we    = 1'b0;
      imem_wdata = {hi_q, load_data};
      finish     = 1'b0;

      unique case (state_q)
         IDLE, LOAD: begin
            if (accept) begin
               state_d = LOAD;
               if (phase_q == HI) begin
                  hi_d    = load_data;
                  phase_d = LO;
                  if (load_last) begin
                     imem_we    = 1'b1;
                     imem_wdata = {load_data, 8'h00};
                     finish     = 1'b1;
                  end
               end else begin
                  imem_we = 1'b1;
                  phase_d = HI;
                  // A full memory ends the load; the pointer never wraps.
                  if (load_last || (ptr_q == PtrMax)) begin
                     finish     = 1'b1;
                     overflow_d = !load_last;
                  end else begin
                     ptr_d = ptr_q + PtrOne;
                  end
               end
               if (finish) begin
                  state_d    = DONE;
                  phase_d    = HI;
                  prog_len_d = {1'b0, ptr_q} + LenOne;
               end
            end
         end
         DONE, RUN: begin
            state_d = RUN;
            if (reload) begin
               state_d    = IDLE;
               phase_d    = HI;
               ptr_d      = '0;
               overflow_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Loader writes take the single port; a coincident fetch is dropped.
   assign imem_addr = imem_we ? ptr_q : pc;
   assign imem_re   = rom_en && !imem_we;

   sync_spram #(
      .AddrWidth(IAW),
      .DataWidth(IW)
   ) u_imem (
      .clk_i  (clk),
      .rst_i  (rst),
      .we_i   (imem_we),
      .re_i   (imem_re),
      .addr_i (imem_addr),
      .wdata_i(imem_wdata),
      .rdata_o(imem_rdata)
   );

   sync_spram #(
      .AddrWidth(DAW),
      .DataWidth(DW)
   ) u_dmem (
      .clk_i  (clk),
      .rst_i  (rst),
      .we_i   (cs_ram && wr_ram),
      .re_i   (cs_ram && !wr_ram),
      .addr_i (addr_ram),
      .wdata_i(ram_wdata),
      .rdata_o(ram_rdata)
   );

   assign ir       = loading ? '0 : imem_rdata;
   assign start    = (state_q == DONE);
   assign cpu_hold = (state_q != RUN);
   assign prog_len = prog_len_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_prog_mem_responder.sv
// Scoreboard bench for prog_mem_responder: stimulus pushes timed expectations,
// a negedge monitor pops and compares them.
module tb_prog_mem_responder;

   localparam int SelIr   = 0;
   localparam int SelRd   = 1;
   localparam int SelSt   = 2;
   localparam int SelHold = 3;
   localparam int SelLen  = 4;
   localparam int SelOvf  = 5;
   localparam int SelLr   = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_last;
   logic        load_ready;
   logic        reload;
   logic [7:0]  pc;
   logic        rom_en;
   logic [15:0] ir;
   logic        cs_ram;
   logic        wr_ram;
   logic [7:0]  addr_ram;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        start;
   logic        cpu_hold;
   logic [8:0]  prog_len;
   logic        overflow;

   prog_mem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .load_valid(load_valid),
      .load_data (load_data),
      .load_last (load_last),
      .load_ready(load_ready),
      .reload    (reload),
      .pc        (pc),
      .rom_en    (rom_en),
      .ir        (ir),
      .cs_ram    (cs_ram),
      .wr_ram    (wr_ram),
      .addr_ram  (addr_ram),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .start     (start),
      .cpu_hold  (cpu_hold),
      .prog_len  (prog_len),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      int          sel;
      logic [15:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] mon_act;

   // Reference model state
   logic [15:0] imem_m [256];
   bit          imem_v [256];
   logic [7:0]  dmem_m [256];
   bit          dmem_v [256];
   logic [7:0]  rd_m;
   logic [8:0]  plen_m;

   function automatic string sel_name(input int s);
      case (s)
         SelIr:   return "ir";
         SelRd:   return "ram_rdata";
         SelSt:   return "start";
         SelHold: return "cpu_hold";
         SelLen:  return "prog_len";
         SelOvf:  return "overflow";
         default: return "load_ready";
      endcase
   endfunction

   function automatic logic [15:0] actual(input int s);
      case (s)
         SelIr:   return ir;
         SelRd:   return {8'h00, ram_rdata};
         SelSt:   return {15'h0, start};
         SelHold: return {15'h0, cpu_hold};
         SelLen:  return {7'h0, prog_len};
         SelOvf:  return {15'h0, overflow};
         default: return {15'h0, load_ready};
      endcase
   endfunction

   task automatic expect_at(input int s, input logic [15:0] v, input int dly);
      sb.push_back('{cyc + dly, s, v});
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            n_cmp++;
            mon_act = actual(sb[i].sel);
            if (sb[i].due != cyc || mon_act !== sb[i].exp) begin
               n_err++;
               $display("FAIL %s @cyc %0d (due %0d): got %h, want %h",
                        sel_name(sb[i].sel), cyc, sb[i].due, mon_act, sb[i].exp);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit last);
      repeat ($urandom_range(0, 2)) begin
         load_valid = 1'b0;
         rom_en     = 1'($urandom);
         pc         = 8'($urandom);
         expect_at(SelLr, 16'd1, 0);
         expect_at(SelIr, 16'd0, 0);
         step();
      end
      load_valid = 1'b1;
      load_data  = b;
      load_last  = last;
      rom_en     = 1'($urandom);
      pc         = 8'($urandom);
      expect_at(SelLr, 16'd1, 0);
      expect_at(SelIr, 16'd0, 0);
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
      rom_en     = 1'b0;
   endtask

   // Words are byte pairs, high byte first; a lone trailing byte pads with 00.
   task automatic load_prog(input logic [7:0] b[$], input bit with_last);
      int n;
      int words;
      bit ovf;
      n = b.size();
      for (int i = 0; i < n; i++) send_byte(b[i], with_last && (i == n - 1));
      words = (n + 1) / 2;
      if (words > 256) words = 256;
      for (int w = 0; w < words; w++) begin
         imem_m[w] = {b[2*w], (2*w + 1 < n) ? b[2*w + 1] : 8'h00};
         imem_v[w] = 1'b1;
      end
      ovf    = !with_last && (n >= 512);
      plen_m = 9'(words);
      expect_at(SelSt,   16'd1, 0);
      expect_at(SelHold, 16'd1, 0);
      expect_at(SelLr,   16'd0, 0);
      expect_at(SelSt,   16'd0, 1);
      expect_at(SelHold, 16'd0, 1);
      expect_at(SelLr,   16'd0, 1);
      expect_at(SelLen,  {7'h0, plen_m}, 1);
      expect_at(SelOvf,  {15'h0, ovf}, 1);
      step();
      step();
   endtask

   task automatic fetch(input logic [7:0] a);
      pc     = a;
      rom_en = 1'b1;
      expect_at(SelIr, imem_m[a], 1);
      step();
      rom_en = 1'b0;
      pc     = 8'($urandom);
      expect_at(SelIr, imem_m[a], 1);
      step();
   endtask

   task automatic ram_write(input logic [7:0] a, input logic [7:0] d);
      cs_ram    = 1'b1;
      wr_ram    = 1'b1;
      addr_ram  = a;
      ram_wdata = d;
      expect_at(SelRd, {8'h00, rd_m}, 1);
      step();
      cs_ram    = 1'b0;
      dmem_m[a] = d;
      dmem_v[a] = 1'b1;
   endtask

   task automatic ram_read(input logic [7:0] a);
      cs_ram   = 1'b1;
      wr_ram   = 1'b0;
      addr_ram = a;
      rd_m     = dmem_m[a];
      expect_at(SelRd, {8'h00, rd_m}, 1);
      step();
      cs_ram    = 1'b0;
      wr_ram    = 1'($urandom);
      addr_ram  = 8'($urandom);
      ram_wdata = 8'($urandom);
      expect_at(SelRd, {8'h00, rd_m}, 1);
      step();
   endtask

   task automatic do_reload();
      reload = 1'b1;
      rom_en = 1'b1;
      pc     = 8'h00;
      expect_at(SelIr,   16'd0, 1);
      expect_at(SelHold, 16'd1, 1);
      expect_at(SelLr,   16'd1, 1);
      expect_at(SelLen,  {7'h0, plen_m}, 1);
      expect_at(SelOvf,  16'd0, 1);
      step();
      reload = 1'b0;
      rom_en = 1'b0;
   endtask

   initial begin
      logic [7:0] bq[$];
      logic [7:0] a;
      rst = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0; reload = 1'b0;
      pc = '0; rom_en = 1'b0; cs_ram = 1'b0; wr_ram = 1'b0; addr_ram = '0; ram_wdata = '0;
      rd_m = 8'h00; plen_m = '0;
      for (int i = 0; i < 256; i++) begin
         imem_v[i] = 1'b0;
         dmem_v[i] = 1'b0;
      end

      // Reset values
      step();
      expect_at(SelLr,   16'd0, 0);
      expect_at(SelIr,   16'd0, 0);
      expect_at(SelRd,   16'd0, 0);
      expect_at(SelSt,   16'd0, 0);
      expect_at(SelHold, 16'd1, 0);
      expect_at(SelLen,  16'd0, 0);
      expect_at(SelOvf,  16'd0, 0);
      step();
      rst = 1'b0;
      expect_at(SelLr, 16'd1, 0);

      // Even-length program, then fetches
      bq = '{8'h12, 8'h34, 8'h56, 8'h78};
      load_prog(bq, 1'b1);
      fetch(8'd1);
      fetch(8'd0);

      // Data RAM directed then random
      ram_write(8'h10, 8'h5A);
      ram_read(8'h10);
      for (int i = 0; i < 24; i++) begin
         a = 8'($urandom);
         if (($urandom % 2 == 0) || !dmem_v[a]) ram_write(a, 8'($urandom));
         else ram_read(a);
      end
      ram_read(8'h10);

      // Odd-length program
      do_reload();
      bq = '{8'h9A, 8'hBC, 8'hDE};
      load_prog(bq, 1'b1);
      fetch(8'd0);
      fetch(8'd1);

      // Random program
      do_reload();
      bq = {};
      repeat ($urandom_range(1, 40)) bq.push_back(8'($urandom));
      load_prog(bq, 1'b1);
      for (int i = 0; i < 6; i++) fetch(8'($urandom_range(0, int'(plen_m) - 1)));

      // Fill memory without load_last
      do_reload();
      bq = {};
      repeat (512) bq.push_back(8'($urandom));
      load_prog(bq, 1'b0);
      expect_at(SelLr, 16'd0, 0);
      fetch(8'd255);
      fetch(8'd0);
      for (int i = 0; i < 4; i++) fetch(8'($urandom));

      // Reset in the middle of a load
      do_reload();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      imem_m[0] = 16'h1122;
      rst = 1'b1;
      expect_at(SelLr, 16'd0, 0);
      step();
      rst    = 1'b0;
      plen_m = '0;
      expect_at(SelLen,  16'd0, 0);
      expect_at(SelHold, 16'd1, 0);
      expect_at(SelSt,   16'd0, 0);
      expect_at(SelIr,   16'd0, 0);
      expect_at(SelLr,   16'd1, 0);
      expect_at(SelOvf,  16'd0, 0);
      bq = '{8'hAB, 8'hCD};
      load_prog(bq, 1'b1);
      fetch(8'd0);
      fetch(8'd1);
      fetch(8'd255);

      step();
      step();
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
